fp_align_shifter: RTL and testbench

//  Pre-add operand alignment for the FPU add/sub path: the inverse of the post-add normaliser.

---
 rtl/fp_align_shifter.sv | 79 +++++++
 tb/tb_fp_align_shifter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fp_align_shifter.sv
// fp_align_shifter: iterative pre-add alignment of the smaller operand's significand,
// shifting at most STEP bits per cycle while collecting guard/round/sticky.
module fp_align_shifter #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_significand,
    input  logic [EXP_W-1:0]  in_exp_small,
    input  logic [EXP_W-1:0]  in_exp_large,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_significand,
    output logic              out_guard,
    output logic              out_round,
    output logic              out_sticky,
    output logic [EXP_W-1:0]  out_exponent,
    output logic              busy
);
    localparam int XW = MANT_W + 3;
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;

    logic [1:0]       state;
    logic [XW-1:0]    ext, ext_shift, lost_mask, ext_next;
    logic [EXP_W-1:0] rem, rem_next, exp_q, diff;
    logic [31:0]      rem_w, k;
    logic             big;

    // Bits falling off the bottom fold into sticky, so it can only ever set.
    always_comb begin
        rem_w     = 32'(rem);
        big       = rem_w >= 32'(XW);
        k         = rem_w < 32'(STEP) ? rem_w : 32'(STEP);
        lost_mask = ~({XW{1'b1}} << k);
        ext_shift = ext >> k;
        ext_next  = big ? {{(XW-1){1'b0}}, |ext}
                        : {ext_shift[XW-1:1], ext_shift[0] | (|(ext & lost_mask))};
        rem_next  = big ? '0 : rem - EXP_W'(k);
        diff      = in_exp_small > in_exp_large ? '0 : in_exp_large - in_exp_small;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ext   <= '0;
            rem   <= '0;
            exp_q <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ext   <= {in_significand, 3'b000};
                    rem   <= diff;
                    exp_q <= in_exp_large;
                    state <= diff == '0 ? DONE : SHIFT;
                end
                SHIFT: begin
                    ext   <= ext_next;
                    rem   <= rem_next;
                    state <= rem_next == '0 ? DONE : SHIFT;
                end
                DONE:    state <= out_ready ? IDLE : DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready        = state == IDLE;
    assign out_valid       = state == DONE;
    assign busy            = state != IDLE;
    assign out_significand = ext[XW-1:3];
    assign out_guard       = ext[2];
    assign out_round       = ext[1];
    assign out_sticky      = ext[0];
    assign out_exponent    = exp_q;
endmodule

// File: tb/tb_fp_align_shifter.sv
// tb_fp_align_shifter: directed vectors feed a scoreboard queue; a negedge monitor
// pops and compares every output handshake, while the driver checks latency and control.
module tb_fp_align_shifter;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 1, busy;
    logic [23:0] in_significand = 0, out_significand;
    logic [7:0]  in_exp_small = 0, in_exp_large = 0, out_exponent;
    logic        out_guard, out_round, out_sticky;
    int          errors = 0, checks = 0;
    logic [35:0] sb_q[$];

    always #5 clk = ~clk;

    fp_align_shifter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_significand(in_significand), .in_exp_small(in_exp_small),
        .in_exp_large(in_exp_large), .out_valid(out_valid), .out_ready(out_ready),
        .out_significand(out_significand), .out_guard(out_guard), .out_round(out_round),
        .out_sticky(out_sticky), .out_exponent(out_exponent), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [35:0] pack_out();
        return {1'b0, out_significand, out_guard, out_round, out_sticky, out_exponent};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: unexpected output %0h with empty scoreboard", pack_out());
            end else begin
                check("result", 64'(pack_out()), 64'(sb_q.pop_front()));
            end
        end
    end

    // Issue one operand, check acceptance and latency; leaves out_valid high on return.
    task automatic issue(input logic [23:0] sig, input logic [7:0] es, input logic [7:0] el,
                         input int lat, input logic [23:0] esig, input logic [2:0] grs,
                         input logic [7:0] eexp);
        int n;
        @(posedge clk); #1;
        check("in_ready before issue", 64'(in_ready), 64'(1));
        in_valid = 1; in_significand = sig; in_exp_small = es; in_exp_large = el;
        sb_q.push_back({1'b0, esig, grs, eexp});
        @(posedge clk); #1;
        in_valid = 0; in_significand = ~sig; in_exp_small = 8'h00; in_exp_large = 8'hFF;
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(lat));
    endtask

    task automatic run(input logic [23:0] sig, input logic [7:0] es, input logic [7:0] el,
                       input int lat, input logic [23:0] esig, input logic [2:0] grs,
                       input logic [7:0] eexp);
        issue(sig, es, el, lat, esig, grs, eexp);
        @(posedge clk); #1;
        check("in_ready after handshake", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [35:0] snap;
        #12;
        check("reset in_ready", 64'(in_ready), 64'(1));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset data", 64'(pack_out()), 64'(0));
        rst_n = 1;
        run(24'hC00000, 8'h7E, 8'h80, 2, 24'h300000, 3'b000, 8'h80);
        run(24'h800001, 8'h90, 8'h90, 1, 24'h800001, 3'b000, 8'h90);
        run(24'hFFFFFF, 8'h80, 8'h8A, 4, 24'h003FFF, 3'b111, 8'h8A);
        run(24'h800000, 8'h62, 8'h80, 2, 24'h000000, 3'b001, 8'h80);
        run(24'h000000, 8'h62, 8'h80, 2, 24'h000000, 3'b000, 8'h80);
        run(24'hFFFFFF, 8'h65, 8'h80, 2, 24'h000000, 3'b001, 8'h80);
        run(24'h800000, 8'h67, 8'h80, 8, 24'h000000, 3'b010, 8'h80);
        run(24'hA00000, 8'h7F, 8'h80, 2, 24'h500000, 3'b000, 8'h80);
        // backpressure
        out_ready = 0;
        issue(24'hC00000, 8'h7E, 8'h80, 2, 24'h300000, 3'b000, 8'h80);
        snap = pack_out();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall outputs", 64'(pack_out()), 64'(snap));
            check("stall out_valid", 64'(out_valid), 64'(1));
            check("stall in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1;
        @(posedge clk); #1;
        check("release in_ready", 64'(in_ready), 64'(1));
        check("release out_valid", 64'(out_valid), 64'(0));
        // async reset during SHIFT
        @(posedge clk); #1;
        in_valid = 1; in_significand = 24'hFFFFFF; in_exp_small = 8'h80; in_exp_large = 8'h8A;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        check("busy in shift", 64'(busy), 64'(1));
        rst_n = 0; #1;
        check("abort out_valid", 64'(out_valid), 64'(0));
        check("abort in_ready", 64'(in_ready), 64'(1));
        check("abort busy", 64'(busy), 64'(0));
        @(posedge clk); #3;
        rst_n = 1;
        run(24'hFFFFFF, 8'h80, 8'h8A, 4, 24'h003FFF, 3'b111, 8'h8A);
        run(24'hABCDEF, 8'h85, 8'h80, 1, 24'hABCDEF, 3'b000, 8'h80);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
